// File: rtl/arb_pkg.sv
// Shared definitions for the two-channel arbiter client: channel state encoding
// and the default timeout / job-length width.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OWN  = 2'd2
   } arb_state_e;

   localparam int TIMEOUT_DEF = 15;
   localparam int LW_DEF      = 4;

endpackage

// File: rtl/arb_client_if.sv
// Job/arbiter bundle for arb_client. The master side is the client itself,
// the slave side is the job source plus the arbiter.
interface arb_client_if
   import arb_pkg::*;
#(
   parameter int LW = LW_DEF
) ();

   // Handshake: a job moves on a rising clk edge where job_valid[i] and job_ready[i]
   // are both 1; grant[i] is honoured only while channel i is requesting.
   logic [1:0]    job_valid;
   logic [LW-1:0] job_len0;
   logic [LW-1:0] job_len1;
   logic [1:0]    job_ready;
   logic [1:0]    grant;
   logic [1:0]    request;
   logic [1:0]    own;
   logic [1:0]    done;
   logic [1:0]    timeout;
   logic          proto_err;
   arb_state_e    state0;
   arb_state_e    state1;

   modport master (
      input  job_valid, job_len0, job_len1, grant,
      output job_ready, request, own, done, timeout, proto_err, state0, state1
   );

   modport slave (
      output job_valid, job_len0, job_len1, grant,
      input  job_ready, request, own, done, timeout, proto_err, state0, state1
   );

endinterface

// File: rtl/arb_client_chan.sv
// One arbiter-client channel: takes a job, requests the bus, owns it for the
// job length in granted cycles, and gives up after TIMEOUT ungranted cycles.
module arb_client_chan
   import arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int LW      = LW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          job_valid,
   input  logic [LW-1:0] job_len,
   input  logic          grant,
   output logic          job_ready,
   output logic          request,
   output logic          own,
   output logic          done,
   output logic          timeout,
   output arb_state_e    state
);

   localparam int WW = $clog2(TIMEOUT + 1);

   logic [LW-1:0] rem;
   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] wait_nxt;

   // Saturating at TIMEOUT keeps the counter from wrapping even if the exit is ever skipped.
   assign wait_nxt = (wait_cnt == WW'(TIMEOUT)) ? wait_cnt : wait_cnt + WW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         wait_cnt  <= '0;
         job_ready <= 1'b1;
         request   <= 1'b0;
         own       <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (job_valid && job_ready) begin
                  rem       <= (job_len == '0) ? LW'(1) : job_len;
                  wait_cnt  <= '0;
                  state     <= REQ;
                  job_ready <= 1'b0;
                  request   <= 1'b1;
               end
            end
            REQ: begin
               if (grant) begin
                  state <= OWN;
                  own   <= 1'b1;
               end else if (wait_nxt == WW'(TIMEOUT)) begin
                  state     <= IDLE;
                  wait_cnt  <= '0;
                  timeout   <= 1'b1;
                  request   <= 1'b0;
                  job_ready <= 1'b1;
               end else begin
                  wait_cnt <= wait_nxt;
               end
            end
            OWN: begin
               // Losing the grant keeps the remaining count; only granted cycles consume it.
               if (!grant) begin
                  state    <= REQ;
                  wait_cnt <= '0;
                  own      <= 1'b0;
               end else if (rem == LW'(1)) begin
                  state     <= IDLE;
                  rem       <= '0;
                  done      <= 1'b1;
                  own       <= 1'b0;
                  request   <= 1'b0;
                  job_ready <= 1'b1;
               end else begin
                  rem <= rem - LW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               own       <= 1'b0;
               request   <= 1'b0;
               job_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/arb_client.sv
// Two independent arbiter-client channels plus a sticky protocol-error flag
// for a grant that is not one-hot-or-zero.
module arb_client
   import arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int LW      = LW_DEF
) (
   input logic          clk,
   input logic          rst,
   arb_client_if.master bus
);

   logic [1:0] ready_w;
   logic [1:0] request_w;
   logic [1:0] own_w;
   logic [1:0] done_w;
   logic [1:0] timeout_w;
   arb_state_e state0_w;
   arb_state_e state1_w;
   logic       proto_err_q;

   arb_client_chan #(.TIMEOUT(TIMEOUT), .LW(LW)) u_chan0 (
      .clk       (clk),
      .rst       (rst),
      .job_valid (bus.job_valid[0]),
      .job_len   (bus.job_len0),
      .grant     (bus.grant[0]),
      .job_ready (ready_w[0]),
      .request   (request_w[0]),
      .own       (own_w[0]),
      .done      (done_w[0]),
      .timeout   (timeout_w[0]),
      .state     (state0_w)
   );

   arb_client_chan #(.TIMEOUT(TIMEOUT), .LW(LW)) u_chan1 (
      .clk       (clk),
      .rst       (rst),
      .job_valid (bus.job_valid[1]),
      .job_len   (bus.job_len1),
      .grant     (bus.grant[1]),
      .job_ready (ready_w[1]),
      .request   (request_w[1]),
      .own       (own_w[1]),
      .done      (done_w[1]),
      .timeout   (timeout_w[1]),
      .state     (state1_w)
   );

   // Channels still follow their own grant bit; the error is only recorded.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err_q <= 1'b0;
      end else if (&bus.grant) begin
         proto_err_q <= 1'b1;
      end
   end

   assign bus.job_ready = ready_w;
   assign bus.request   = request_w;
   assign bus.own       = own_w;
   assign bus.done      = done_w;
   assign bus.timeout   = timeout_w;
   assign bus.proto_err = proto_err_q;
   assign bus.state0    = state0_w;
   assign bus.state1    = state1_w;

endmodule

// File: tb/tb_arb_client.sv
// Bench for arb_client paired with a registered priority arbiter (request[0] wins);
// done/timeout pulses are checked against an expected-event queue.
module tb_arb_client;
   import arb_pkg::*;

   localparam int TO = 15;
   localparam int LW = 4;
   localparam int W  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   arb_client_if #(.LW(LW)) bus ();

   arb_client #(.TIMEOUT(TO), .LW(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #50 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered priority arbiter; mask/force let the bench starve or corrupt the grant lines.
   logic [1:0] arb_q;
   logic [1:0] grant_mask;
   logic [1:0] grant_force;

   always @(posedge clk) begin
      if (rst) arb_q <= 2'b00;
      else if (bus.request[0]) arb_q <= 2'b01;
      else if (bus.request[1]) arb_q <= 2'b10;
      else arb_q <= 2'b00;
   end

   assign bus.grant = (arb_q & grant_mask) | grant_force;

   logic [W-1:0] exp_q[$];
   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] mon_obs;
   logic [W-1:0] mon_exp;

   // Event word: {kind (01 done, 10 timeout), channel, cycle of the pulse}.
   function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic ch, input int c);
      logic [16:0] c17;
      c17 = c[16:0];
      return {kind, ch, c17};
   endfunction

   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (bus.done[ch] || bus.timeout[ch]) begin
            mon_obs = ev({bus.timeout[ch], bus.done[ch]}, ch[0], cyc);
            n_chk++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL unexpected_pulse observed=%h expected=none", mon_obs);
            end
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               n_chk++;
               assert (mon_obs === mon_exp) else begin
                  n_fail++;
                  $error("FAIL pulse_event observed=%h expected=%h", mon_obs, mon_exp);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic offer(input logic [1:0] v, input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                        output int a);
      bus.job_valid = v;
      bus.job_len0  = l0;
      bus.job_len1  = l1;
      a = cyc + 1;
      @(negedge clk);
      bus.job_valid = 2'b00;
   endtask

   int a;

   initial begin
      bus.job_valid = 2'b00;
      bus.job_len0  = '0;
      bus.job_len1  = '0;
      grant_mask    = 2'b11;
      grant_force   = 2'b00;
      rst           = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_job_ready", 32'(bus.job_ready), 32'h3);
      chk("rst_request", 32'(bus.request), 32'h0);
      chk("rst_own", 32'(bus.own), 32'h0);
      chk("rst_pulses", 32'({bus.done, bus.timeout}), 32'h0);
      chk("rst_proto_err", 32'(bus.proto_err), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Basic job on ch0, len 3, with a second offer while busy that must be dropped.
      offer(2'b01, 4'd3, 4'd0, a);
      exp_q.push_back(ev(2'b01, 1'b0, a + 2 + 3));
      chk("basic_req_rise", 32'(bus.request), 32'h1);
      chk("basic_not_ready", 32'(bus.job_ready), 32'h2);
      chk("basic_state_req", 32'(bus.state0), 32'(REQ));
      bus.job_valid = 2'b01;
      bus.job_len0  = 4'd1;
      wait_to(a + 1);
      bus.job_valid = 2'b00;
      chk("basic_grant", 32'(bus.grant), 32'h1);
      chk("basic_own_pre", 32'(bus.own), 32'h0);
      wait_to(a + 2);
      chk("basic_own_1", 32'(bus.own), 32'h1);
      chk("basic_state_own", 32'(bus.state0), 32'(OWN));
      wait_to(a + 4);
      chk("basic_own_3", 32'(bus.own), 32'h1);
      wait_to(a + 5);
      chk("basic_req_fall", 32'(bus.request), 32'h0);
      chk("basic_own_end", 32'(bus.own), 32'h0);
      wait_to(a + 6);
      chk("basic_done_once", 32'(bus.done), 32'h0);
      chk("basic_ready_back", 32'(bus.job_ready), 32'h3);
      repeat (3) @(negedge clk);

      // Length 0 behaves as length 1.
      offer(2'b01, 4'd0, 4'd0, a);
      exp_q.push_back(ev(2'b01, 1'b0, a + 3));
      wait_to(a + 4);
      chk("len0_ready", 32'(bus.job_ready), 32'h3);
      repeat (2) @(negedge clk);

      // Contention: ch0 wins, ch1 follows once request[0] drops.
      offer(2'b11, 4'd2, 4'd2, a);
      exp_q.push_back(ev(2'b01, 1'b0, a + 4));
      exp_q.push_back(ev(2'b01, 1'b1, a + 8));
      chk("cont_both_req", 32'(bus.request), 32'h3);
      wait_to(a + 4);
      chk("cont_req_after_done0", 32'(bus.request), 32'h2);
      wait_to(a + 6);
      chk("cont_own1", 32'(bus.own), 32'h2);
      wait_to(a + 9);
      chk("cont_ready", 32'(bus.job_ready), 32'h3);
      repeat (2) @(negedge clk);

      // Timeout on ch1 with grant tied low.
      grant_mask = 2'b00;
      offer(2'b10, 4'd0, 4'd4, a);
      exp_q.push_back(ev(2'b10, 1'b1, a + TO));
      wait_to(a + TO - 1);
      chk("to_still_req", 32'(bus.request), 32'h2);
      chk("to_no_pulse_yet", 32'(bus.timeout), 32'h0);
      wait_to(a + TO);
      chk("to_req_fall", 32'(bus.request), 32'h0);
      chk("to_ready", 32'(bus.job_ready), 32'h3);
      wait_to(a + TO + 1);
      chk("to_req_next", 32'(bus.request), 32'h0);
      wait_to(a + TO + 2);
      grant_mask = 2'b11;
      repeat (2) @(negedge clk);

      // Preemption: ch1 len 5 loses grant after two consumed cycles, then owns three more.
      offer(2'b10, 4'd0, 4'd5, a);
      exp_q.push_back(ev(2'b01, 1'b1, a + 10));
      wait_to(a + 2);
      chk("pre_own_a", 32'(bus.own), 32'h2);
      wait_to(a + 4);
      chk("pre_own_b", 32'(bus.own), 32'h2);
      grant_mask = 2'b01;
      wait_to(a + 5);
      chk("pre_lost_own", 32'(bus.own), 32'h0);
      chk("pre_keep_req", 32'(bus.request), 32'h2);
      chk("pre_state_req", 32'(bus.state1), 32'(REQ));
      wait_to(a + 6);
      grant_mask = 2'b11;
      wait_to(a + 7);
      chk("pre_regrant", 32'(bus.own), 32'h2);
      wait_to(a + 9);
      chk("pre_own_last", 32'(bus.own), 32'h2);
      wait_to(a + 10);
      chk("pre_own_end", 32'(bus.own), 32'h0);
      repeat (3) @(negedge clk);

      // Reset while ch0 owns the bus: job dropped silently.
      offer(2'b01, 4'd8, 4'd0, a);
      wait_to(a + 3);
      chk("rstjob_own", 32'(bus.own), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstjob_request", 32'(bus.request), 32'h0);
      chk("rstjob_own_clr", 32'(bus.own), 32'h0);
      chk("rstjob_ready", 32'(bus.job_ready), 32'h3);
      chk("rstjob_pulses", 32'({bus.done, bus.timeout}), 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Protocol error: grant 2'b11 for one edge, sticky until reset.
      chk("perr_clear", 32'(bus.proto_err), 32'h0);
      grant_force = 2'b11;
      @(negedge clk);
      grant_force = 2'b00;
      chk("perr_set", 32'(bus.proto_err), 32'h1);
      repeat (3) @(negedge clk);
      chk("perr_sticky", 32'(bus.proto_err), 32'h1);
      chk("perr_idle_ignore", 32'(bus.job_ready), 32'h3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("perr_reset", 32'(bus.proto_err), 32'h0);
      repeat (2) @(negedge clk);

      chk("pending_events", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_client.md
ARB_CLIENT -- requirements
Module: arb_client

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles a channel waits in REQ for grant before abandoning.
REQ-002 Parameter LW, default 4: width of each job length field.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 job_valid  input  2  per-channel job offer; bit i belongs to channel i.
REQ-006 job_len0 / job_len1  input  LW each  ownership length in cycles for channel 0 / 1.
REQ-007 job_ready  output  2  channel i idle and able to accept a job.
REQ-008 grant  input  2  arbiter grant lines, one-hot or zero.
REQ-009 request  output  2  registered request lines to the arbiter.
REQ-010 own  output  2  channel i currently holds the bus.
REQ-011 done  output  2  one-cycle pulse: channel i completed its job.
REQ-012 timeout  output  2  one-cycle pulse: channel i abandoned its request.
REQ-013 proto_err  output  1  sticky flag: both grant bits seen high on the same edge.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, REQ, OWN.
REQ-015 IDLE: job_ready[i]=1, request[i]=0; on job_valid[i]&job_ready[i], latch the length (a length of 0 is taken as 1), clear the wait counter, and go to REQ.
REQ-016 request[i] SHALL be 1 in every cycle the channel is in REQ or OWN, and 0 otherwise.
REQ-017 REQ: when grant[i]=1 is sampled, go to OWN; otherwise increment the wait counter.
REQ-018 REQ: if the wait counter reaches TIMEOUT with no grant, go to IDLE and assert timeout[i] for exactly one cycle.
REQ-019 OWN: own[i]=1; each edge with grant[i]=1 decrements the remaining count.
REQ-020 OWN: on the edge where remaining==1 and grant[i]=1, go to IDLE and assert done[i] for exactly one cycle.
REQ-021 OWN: if grant[i]=0 is sampled (preemption), return to REQ, keep the remaining count, clear the wait counter, and do not decrement.
REQ-022 grant[i] sampled while channel i is in IDLE SHALL be ignored.
REQ-023 job_ready[i] SHALL be 0 in REQ and OWN; job_valid[i] presented then SHALL be ignored, not queued.
REQ-024 If grant==2'b11 is sampled, proto_err SHALL set and hold until rst; both channels treat their own grant bit normally.
REQ-025 done and timeout SHALL be mutually exclusive per channel; a new job SHALL be acceptable in the cycle after done or timeout.
REQ-026 The wait counter SHALL be wide enough for TIMEOUT and SHALL saturate rather than wrap.

Reset
REQ-027 On rst, both FSMs SHALL enter IDLE and all counters SHALL clear.
REQ-028 Reset values: request=0, own=0, done=0, timeout=0, proto_err=0, job_ready=2'b11 (first cycle after reset).
REQ-029 rst asserted mid-job SHALL abandon the job with no done or timeout pulse.

Structure
REQ-030 A shared package arb_pkg SHALL hold the state enum (IDLE, REQ, OWN) and the TIMEOUT / LW defaults.
REQ-031 The per-channel FSM SHALL be a sub-module arb_client_chan, instantiated twice; arb_client adds only the proto_err logic and wiring.

Verification
REQ-032 The bench SHALL pair arb_client with the priority arbiter (request[0] wins, grant registered), clocked at 100-unit period.
REQ-033 Basic: job on ch0, len=3 -> request[0] rises 1 cycle after accept; grant[0] one cycle later; own[0] high 3 grant cycles; done[0] pulses once; request[0] falls with done.
REQ-034 Contention: ch0 len=2 and ch1 len=2 in the same cycle -> ch0 completes first; ch1 granted after request[0] drops; both done pulses seen, ch0's earlier.
REQ-035 Timeout: grant tied 0, ch1 job -> timeout[1] pulses exactly TIMEOUT cycles after entering REQ; request[1] low the next cycle; no done.
REQ-036 Preemption: ch1 owning with len=5, grant[1] forced low for 2 cycles after 2 owned cycles -> ch1 re-enters REQ; on re-grant it owns 3 more cycles, then done[1].
REQ-037 Reset and errors: rst in OWN -> next cycle request=0, own=0, job_ready=2'b11, no pulses; grant=2'b11 injected -> proto_err=1 until rst.
